// File: rtl/sim_spi_dac_model_if.sv
// SPI bus between a DAC SPI master and the DAC model: serial lines, load/clear strobes and the daisy-chain echo.
interface sim_spi_dac_model_if;
  logic sck;
  logic sdi;
  logic csld;
  logic ldac;
  logic clr;
  logic sdo;

  modport master (output sck, output sdi, output csld, output ldac, output clr, input sdo);
  modport slave  (input sck, input sdi, input csld, input ldac, input clr, output sdo);
endinterface

// File: rtl/sim_spi_dac_model.sv
// Cycle-accurate model of an LTC2656-class SPI DAC with input/DAC register pairs, LDAC/CLR strobes,
// frame-length checking and a daisy-chain SDO echo. All SPI lines are sampled on clk.
module sim_spi_dac_model #(
  parameter int                    CHANNELS        = 8,
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    WORD_BITS       = 24,
  parameter logic [DATA_WIDTH-1:0] UNPOWERED_VALUE = '1
) (
  input  logic                           clk,
  input  logic                           resetn,
  sim_spi_dac_model_if.slave             spi,
  output logic [CHANNELS*DATA_WIDTH-1:0] dac_out,
  output logic [CHANNELS*DATA_WIDTH-1:0] inp_out,
  output logic [CHANNELS-1:0]            powered,
  output logic                           internal_vref,
  output logic [23:0]                    spi_dataword_out,
  output logic                           frame_error,
  output logic [15:0]                    frame_count
);

  localparam logic [5:0] WORD_LEN = 6'(WORD_BITS);
  localparam logic [5:0] CNT_MAX  = 6'd63;

  typedef logic [DATA_WIDTH-1:0] val_t;

  logic                           sck_q, csld_q, ldac_q, clr_q;
  logic [WORD_BITS-1:0]           sr_q, sr_d;
  logic [5:0]                     cnt_q, cnt_d;
  val_t                           inp_q [CHANNELS];
  val_t                           inp_d [CHANNELS];
  val_t                           dac_q [CHANNELS];
  val_t                           dac_d [CHANNELS];
  logic [CHANNELS-1:0]            pwr_q, pwr_d;
  logic                           vref_q, vref_d;
  logic [23:0]                    word_q, word_d;
  logic                           ferr_q, ferr_d;
  logic [15:0]                    fcnt_q, fcnt_d;
  logic [CHANNELS*DATA_WIDTH-1:0] dac_out_q, dac_out_d;

  logic                sck_rise_s, csld_fall_s, csld_rise_s, ldac_fall_s, clr_fall_s;
  logic [3:0]          cmd_s, ch_s;
  val_t                val_s;
  logic [CHANNELS-1:0] sel_s;

  assign sck_rise_s  = ~sck_q & spi.sck;
  assign csld_fall_s = csld_q & ~spi.csld;
  assign csld_rise_s = ~csld_q & spi.csld;
  assign ldac_fall_s = ldac_q & ~spi.ldac;
  assign clr_fall_s  = clr_q & ~spi.clr;

  // Command fields always come from the newest 24 bits; the value is left-justified in [15:0].
  assign cmd_s = sr_q[23:20];
  assign ch_s  = sr_q[19:16];
  assign val_s = val_t'(sr_q[15 -: DATA_WIDTH]);

  // Channel select decode: 4'hF addresses every channel, out-of-range addresses select none.
  always_comb begin
    sel_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sel_s[c] = (ch_s == 4'hF) || (ch_s == 4'(c));
    end
  end

  // Next-state: shift path, then command, then LDAC, then CLR so later steps win on conflicts.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = csld_fall_s ? 6'd0 : cnt_q;
    inp_d  = inp_q;
    dac_d  = dac_q;
    pwr_d  = pwr_q;
    vref_d = vref_q;
    word_d = word_q;
    ferr_d = 1'b0;
    fcnt_d = fcnt_q;

    if (sck_rise_s && !spi.csld) begin
      sr_d  = {sr_q[WORD_BITS-2:0], spi.sdi};
      cnt_d = (cnt_d == CNT_MAX) ? CNT_MAX : cnt_d + 6'd1;
    end else begin
      sr_d = sr_q;
    end

    if (csld_rise_s && (cnt_q != WORD_LEN)) begin
      ferr_d = 1'b1;
    end else if (csld_rise_s) begin
      word_d = sr_q[23:0];
      fcnt_d = fcnt_q + 16'd1;
      case (cmd_s)
        4'h0: begin
          for (int c = 0; c < CHANNELS; c++) inp_d[c] = sel_s[c] ? val_s : inp_q[c];
        end
        4'h1: begin
          for (int c = 0; c < CHANNELS; c++) dac_d[c] = sel_s[c] ? inp_q[c] : dac_q[c];
          pwr_d = pwr_q | sel_s;
        end
        4'h2: begin
          for (int c = 0; c < CHANNELS; c++) begin
            inp_d[c] = sel_s[c] ? val_s : inp_q[c];
            dac_d[c] = inp_d[c];
          end
          pwr_d = '1;
        end
        4'h3: begin
          for (int c = 0; c < CHANNELS; c++) begin
            inp_d[c] = sel_s[c] ? val_s : inp_q[c];
            dac_d[c] = sel_s[c] ? val_s : dac_q[c];
          end
          pwr_d = pwr_q | sel_s;
        end
        4'h4: pwr_d = pwr_q & ~sel_s;
        4'h5: begin
          pwr_d  = '0;
          vref_d = 1'b0;
        end
        4'h6: vref_d = 1'b1;
        4'h7: vref_d = 1'b0;
        default: vref_d = vref_q;
      endcase
    end else begin
      ferr_d = 1'b0;
    end

    // LDAC transfers the input values as they stood before any same-cycle command.
    if (ldac_fall_s) begin
      dac_d = inp_q;
      pwr_d = '1;
    end else begin
      pwr_d = pwr_d;
    end

    if (clr_fall_s) begin
      for (int c = 0; c < CHANNELS; c++) begin
        inp_d[c] = '0;
        dac_d[c] = '0;
      end
    end else begin
      vref_d = vref_d;
    end

    dac_out_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      dac_out_d[c*DATA_WIDTH +: DATA_WIDTH] = pwr_d[c] ? dac_d[c] : UNPOWERED_VALUE;
    end
  end

  // State registers; prior csld resets high so reset release never looks like a frame edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_q     <= 1'b0;
      csld_q    <= 1'b1;
      ldac_q    <= 1'b0;
      clr_q     <= 1'b0;
      sr_q      <= '0;
      cnt_q     <= 6'd0;
      for (int c = 0; c < CHANNELS; c++) begin
        inp_q[c] <= '0;
        dac_q[c] <= '0;
      end
      pwr_q     <= '0;
      vref_q    <= 1'b1;
      word_q    <= 24'd0;
      ferr_q    <= 1'b0;
      fcnt_q    <= 16'd0;
      dac_out_q <= {CHANNELS{UNPOWERED_VALUE}};
    end else begin
      sck_q     <= spi.sck;
      csld_q    <= spi.csld;
      ldac_q    <= spi.ldac;
      clr_q     <= spi.clr;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      inp_q     <= inp_d;
      dac_q     <= dac_d;
      pwr_q     <= pwr_d;
      vref_q    <= vref_d;
      word_q    <= word_d;
      ferr_q    <= ferr_d;
      fcnt_q    <= fcnt_d;
      dac_out_q <= dac_out_d;
    end
  end

  // Input registers are exposed unconditionally, packed like dac_out.
  always_comb begin
    inp_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      inp_out[c*DATA_WIDTH +: DATA_WIDTH] = inp_q[c];
    end
  end

  assign spi.sdo          = spi.csld ? 1'b0 : sr_q[WORD_BITS-1];
  assign dac_out          = dac_out_q;
  assign powered          = pwr_q;
  assign internal_vref    = vref_q;
  assign spi_dataword_out = word_q;
  assign frame_error      = ferr_q;
  assign frame_count      = fcnt_q;

endmodule

// File: tb/tb_sim_spi_dac_model.sv
// Scoreboard bench: a spec-level DAC model predicts every register state and the SDO echo, monitors compare.
module tb_sim_spi_dac_model;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sim_spi_dac_model_if bus ();
  sim_spi_dac_model_if bus12 ();

  assign bus12.sck  = bus.sck;
  assign bus12.sdi  = bus.sdi;
  assign bus12.csld = bus.csld;
  assign bus12.ldac = bus.ldac;
  assign bus12.clr  = bus.clr;

  logic [127:0] dac_out, inp_out;
  logic [7:0]   powered;
  logic         internal_vref, frame_error;
  logic [23:0]  spi_dataword_out;
  logic [15:0]  frame_count;

  logic [95:0]  dac_out12, inp_out12;
  logic [7:0]   powered12;
  logic         internal_vref12, frame_error12;
  logic [23:0]  spi_dataword_out12;
  logic [15:0]  frame_count12;

  sim_spi_dac_model u_dut (
    .clk(clk), .resetn(resetn), .spi(bus),
    .dac_out(dac_out), .inp_out(inp_out), .powered(powered),
    .internal_vref(internal_vref), .spi_dataword_out(spi_dataword_out),
    .frame_error(frame_error), .frame_count(frame_count)
  );

  sim_spi_dac_model #(.DATA_WIDTH(12)) u_dut12 (
    .clk(clk), .resetn(resetn), .spi(bus12),
    .dac_out(dac_out12), .inp_out(inp_out12), .powered(powered12),
    .internal_vref(internal_vref12), .spi_dataword_out(spi_dataword_out12),
    .frame_error(frame_error12), .frame_count(frame_count12)
  );

  typedef struct packed {
    logic [127:0] dac;
    logic [127:0] inp;
    logic [7:0]   pwr;
    logic         vref;
    logic [23:0]  word;
    logic         ferr;
    logic [15:0]  fcnt;
  } snap_t;

  snap_t exp_q[$];
  bit    sdo_q[$];
  bit    hist[$];

  // Reference model state (16-bit resolution; the 12-bit instance is its top 12 bits).
  logic [15:0] m_inp [8];
  logic [15:0] m_dac [8];
  logic [7:0]  m_pwr;
  logic        m_vref;
  logic [23:0] m_word;
  logic [15:0] m_fcnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit obs_req  = 1'b0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic snap_t snapshot(bit ferr);
    snap_t s;
    for (int c = 0; c < 8; c++) begin
      s.dac[c*16 +: 16] = m_pwr[c] ? m_dac[c] : 16'hFFFF;
      s.inp[c*16 +: 16] = m_inp[c];
    end
    s.pwr  = m_pwr;
    s.vref = m_vref;
    s.word = m_word;
    s.ferr = ferr;
    s.fcnt = m_fcnt;
    return s;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 8; c++) begin
      m_inp[c] = 16'h0;
      m_dac[c] = 16'h0;
    end
    m_pwr  = 8'h00;
    m_vref = 1'b1;
    m_word = 24'h0;
    m_fcnt = 16'h0;
    hist.delete();
  endfunction

  // One clk-cycle worth of events: optional executed frame, ldac fall, clr fall.
  function automatic void model_event(bit is_frame, int nbits, logic [23:0] w, bit ldac, bit clr);
    logic [15:0] pre [8];
    bit          ferr = 1'b0;
    logic [3:0]  cmd = w[23:20];
    logic [3:0]  ch  = w[19:16];
    logic [15:0] v   = w[15:0];
    logic [7:0]  sel = 8'h00;
    pre = m_inp;
    for (int c = 0; c < 8; c++) sel[c] = (ch == 4'hF) || (int'(ch) == c);
    if (is_frame && nbits != 24) begin
      ferr = 1'b1;
    end else if (is_frame) begin
      m_word = w;
      m_fcnt = m_fcnt + 16'd1;
      for (int c = 0; c < 8; c++) begin
        if (cmd == 4'h0 && sel[c]) m_inp[c] = v;
        if (cmd == 4'h1 && sel[c]) begin m_dac[c] = m_inp[c]; m_pwr[c] = 1'b1; end
        if (cmd == 4'h2 && sel[c]) m_inp[c] = v;
        if (cmd == 4'h3 && sel[c]) begin m_inp[c] = v; m_dac[c] = v; m_pwr[c] = 1'b1; end
        if (cmd == 4'h4 && sel[c]) m_pwr[c] = 1'b0;
      end
      if (cmd == 4'h2) begin m_dac = m_inp; m_pwr = 8'hFF; end
      if (cmd == 4'h5) begin m_pwr = 8'h00; m_vref = 1'b0; end
      if (cmd == 4'h6) m_vref = 1'b1;
      if (cmd == 4'h7) m_vref = 1'b0;
    end
    if (ldac) begin m_dac = pre; m_pwr = 8'hFF; end
    if (clr) for (int c = 0; c < 8; c++) begin m_inp[c] = 16'h0; m_dac[c] = 16'h0; end
    exp_q.push_back(snapshot(ferr));
  endfunction

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      check("response_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(int nbits, logic [127:0] bits, bit with_ldac);
    @(negedge clk) bus.csld = 1'b0;
    @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.sdi = bits[i];
      sdo_q.push_back(hist.size() == 24 ? hist[0] : 1'b0);
      hist.push_back(bits[i]);
      if (hist.size() > 24) void'(hist.pop_front());
      @(negedge clk) bus.sck = 1'b1;
      @(negedge clk);
      @(negedge clk) bus.sck = 1'b0;
    end
    @(negedge clk);
    model_event(1'b1, nbits, bits[23:0], with_ldac, 1'b0);
    bus.csld = 1'b1;
    if (with_ldac) bus.ldac = 1'b0;
    repeat (2) @(negedge clk);
    bus.ldac = 1'b1;
    wait_drain();
  endtask

  task automatic pulse(bit l, bit c);
    @(negedge clk);
    model_event(1'b0, 0, 24'h0, l, c);
    if (l) bus.ldac = 1'b0;
    if (c) bus.clr = 1'b0;
    repeat (2) @(negedge clk);
    bus.ldac = 1'b1;
    bus.clr  = 1'b1;
    obs_req  = 1'b1;
    wait_drain();
  endtask

  // Register-state monitor: fires on a frame_count change, a frame_error pulse or a strobe observation.
  initial begin
    logic [15:0]  last_fcnt = 16'h0;
    logic [95:0]  e12_dac, e12_inp;
    snap_t        e;
    forever begin
      @(negedge clk);
      if (resetn && (frame_error || frame_count !== last_fcnt || obs_req)) begin
        obs_req   = 1'b0;
        last_fcnt = frame_count;
        if (exp_q.size() == 0) begin
          check("unexpected_output_event", 128'(frame_count), 128'(m_fcnt));
        end else begin
          e = exp_q.pop_front();
          for (int c = 0; c < 8; c++) begin
            e12_dac[c*12 +: 12] = e.dac[c*16+4 +: 12];
            e12_inp[c*12 +: 12] = e.inp[c*16+4 +: 12];
          end
          check("dac_out", dac_out, e.dac);
          check("inp_out", inp_out, e.inp);
          check("powered", 128'(powered), 128'(e.pwr));
          check("internal_vref", 128'(internal_vref), 128'(e.vref));
          check("spi_dataword_out", 128'(spi_dataword_out), 128'(e.word));
          check("frame_error", 128'(frame_error), 128'(e.ferr));
          check("frame_count", 128'(frame_count), 128'(e.fcnt));
          check("dac_out_12b", 128'(dac_out12), 128'(e12_dac));
          check("inp_out_12b", 128'(inp_out12), 128'(e12_inp));
          check("powered_12b", 128'(powered12), 128'(e.pwr));
          check("frame_count_12b", 128'(frame_count12), 128'(e.fcnt));
          if (e.ferr) begin
            @(negedge clk);
            check("frame_error_width", 128'(frame_error), 128'd0);
          end
        end
      end
    end
  end

  // SDO monitor: the echo bit is compared just after every sck rise.
  initial begin
    forever begin
      @(posedge bus.sck);
      #1;
      if (sdo_q.size() == 0) begin
        check("sdo_unexpected", 128'(bus.sdo), 128'd0);
      end else begin
        check("sdo", 128'(bus.sdo), 128'(sdo_q.pop_front()));
        check("sdo_12b", 128'(bus12.sdo), 128'(bus.sdo));
      end
    end
  end

  initial begin
    logic [127:0] bits;
    int           r, nb;
    logic [3:0]   cmd, ch;
    resetn   = 1'b0;
    bus.sck  = 1'b0;
    bus.sdi  = 1'b0;
    bus.csld = 1'b1;
    bus.ldac = 1'b1;
    bus.clr  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    exp_q.push_back(snapshot(1'b0));
    obs_req = 1'b1;
    wait_drain();

    send_frame(24, 128'h321234, 1'b0);
    send_frame(24, 128'h05ABCD, 1'b0);
    pulse(1'b1, 1'b0);
    send_frame(24, 128'h2F5555, 1'b0);
    pulse(1'b0, 1'b1);
    send_frame(20, 128'h3_1234, 1'b0);
    send_frame(25, 128'h1_321234, 1'b0);
    send_frame(88, {64'h0123_4567_89AB_CDEF, 64'h0000_0000_0035_7777}, 1'b0);
    send_frame(24, 128'h091111, 1'b0);
    send_frame(24, 128'h500000, 1'b0);
    send_frame(24, 128'hA5A5A5, 1'b0);
    send_frame(24, 128'h000000, 1'b0);
    send_frame(24, 128'h30ABCD, 1'b0);
    send_frame(24, 128'h041111, 1'b0);
    send_frame(24, 128'h0F2222, 1'b1);
    pulse(1'b1, 1'b1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        pulse(1'b1, 1'b0);
      end else if (r == 1) begin
        pulse(1'b0, 1'b1);
      end else if (r == 2) begin
        nb = $urandom_range(1, 40);
        if (nb == 24) nb = 23;
        bits = {$urandom, $urandom, $urandom, $urandom};
        send_frame(nb, bits, 1'b0);
      end else begin
        cmd  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        ch   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
        bits = 128'({cmd, ch, 16'($urandom)});
        send_frame(24, bits, r == 3);
      end
    end

    if (sdo_q.size() != 0) check("sdo_leftover", 128'(sdo_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
